// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_ctrl_pkg
// Brief    : Shared widths and FSM state encoding for the RAM bus initiator.
// Revision : 1.0 - initial release
// ============================================================================
package ram_ctrl_pkg;

    // Default bus geometry: 4096 x 8 RAM
    localparam int c_ADDR_W = 12;
    localparam int c_DATA_W = 8;

    // Width of the wait-state down-counter (WAIT_CYCLES up to 15)
    localparam int c_CNT_W  = 4;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_SETUP   = 3'd1;
    localparam state_t c_ST_ACCESS  = 3'd2;
    localparam state_t c_ST_TURN    = 3'd3;
    localparam state_t c_ST_VSETUP  = 3'd4;
    localparam state_t c_ST_VACCESS = 3'd5;

endpackage
`default_nettype wire

// File: rtl/ram_ctrl_wait_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ram_ctrl_wait_cnt
// Brief    : Loadable down-counter with zero flag; times the enable-asserted
//            phases of a RAM access.
// Revision : 1.0 - initial release
// ============================================================================
module ram_ctrl_wait_cnt
    import ram_ctrl_pkg::*;
#(
    parameter int CNT_W = c_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority; decrement saturates at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_ctrl
// Brief    : Bus initiator converting a valid/ready request interface into the
//            RAM enable/write_enable/address/tri-state data protocol.
// Options  : RAM_CTRL_READBACK_EN - every write is followed by a read-back of
//            the same address; a mismatch is flagged on rsp_err.
// Revision : 1.0 - initial release
// ============================================================================
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = c_ADDR_W,
    parameter int DATA_W      = c_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              ram_enable,
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_address,
    inout  wire  [DATA_W-1:0] ram_data
);

    // Counter reload so that ACCESS lasts exactly WAIT_CYCLES cycles
    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD = c_CNT_W'(WAIT_CYCLES - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_ready;
    logic                w_cnt_load;
    logic                w_cnt_dec;
    logic                w_cnt_zero;
    logic                w_enable;
    logic                w_write_enable;
    logic                w_drive;
    logic                w_rsp_valid;
    logic                w_capture;
`ifdef RAM_CTRL_READBACK_EN
    logic                w_verify;
    logic                r_err;
`endif

    ram_ctrl_wait_cnt #(
        .CNT_W (c_CNT_W)
    ) u_wait_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (c_WAIT_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // State register; async reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and bus-control decode
    always_comb begin
        w_next_state   = r_state;
        w_ready        = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_dec      = 1'b0;
        w_enable       = 1'b0;
        w_write_enable = 1'b0;
        w_drive        = 1'b0;
        w_rsp_valid    = 1'b0;
        w_capture      = 1'b0;
`ifdef RAM_CTRL_READBACK_EN
        w_verify       = 1'b0;
`endif
        case (r_state)
            c_ST_IDLE: begin
                w_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = c_ST_SETUP;
                end
            end
            c_ST_SETUP: begin
                w_drive      = r_we;
                w_cnt_load   = 1'b1;
                w_next_state = c_ST_ACCESS;
            end
            c_ST_ACCESS: begin
                w_enable       = 1'b1;
                w_write_enable = r_we;
                w_drive        = r_we;
                if (w_cnt_zero) begin
`ifdef RAM_CTRL_READBACK_EN
                    if (r_we) begin
                        w_next_state = c_ST_VSETUP;
                    end else begin
                        w_capture    = 1'b1;
                        w_next_state = c_ST_TURN;
                    end
`else
                    w_capture    = ~r_we;
                    w_next_state = c_ST_TURN;
`endif
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
`ifdef RAM_CTRL_READBACK_EN
            c_ST_VSETUP: begin
                // Bus released for a full cycle before the RAM drives it
                w_cnt_load   = 1'b1;
                w_next_state = c_ST_VACCESS;
            end
            c_ST_VACCESS: begin
                w_enable = 1'b1;
                if (w_cnt_zero) begin
                    w_verify     = 1'b1;
                    w_next_state = c_ST_TURN;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
`endif
            c_ST_TURN: begin
                w_rsp_valid  = 1'b1;
`ifndef RAM_CTRL_READBACK_EN
                // Hold write data one cycle past the enable drop
                w_drive      = r_we;
`endif
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Request capture on handshake and read-data capture at end of ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_ready && req_valid) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_capture) begin
                r_rdata <= ram_data;
            end
        end
    end

`ifdef RAM_CTRL_READBACK_EN
    // Read-back compare flag, cleared when a new request is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_ready && req_valid) begin
            r_err <= 1'b0;
        end else if (w_verify) begin
            r_err <= (ram_data != r_wdata);
        end
    end

    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign req_ready        = w_ready;
    assign rsp_valid        = w_rsp_valid;
    assign rsp_rdata        = r_rdata;
    assign ram_enable       = w_enable;
    assign ram_write_enable = w_write_enable;
    assign ram_address      = r_addr;
    assign ram_data         = w_drive ? r_wdata : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Bus initiator for the 12-bit-address / 8-bit-data RAM.
- Converts a clocked valid/ready request interface from the CPU core into the RAM's level-driven enable/write_enable/address/tri-state data protocol.
- Owns bus sequencing: address setup, wait states, read capture and data-bus turnaround, so the core never drives the shared data bus directly.

Parameters:
- ADDR_W, 12, address width; matches the RAM depth of 4096.
- DATA_W, 8, data bus width.
- WAIT_CYCLES, 1, number of cycles enable is held asserted per access; legal range 1..15.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_rdata  out  DATA_W  read data; held until the next read completes.
- rsp_err  out  1  read-back mismatch flag, valid with rsp_valid.
- ram_enable  out  1  to RAM enable.
- ram_write_enable  out  1  to RAM write_enable.
- ram_address  out  ADDR_W  to RAM address.
- ram_data  inout  DATA_W  shared RAM data bus.

Behaviour:
- Reset (async assert, sync release) puts the block in this state:
  - state = IDLE, req_ready = 1.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - ram_enable = 0, ram_write_enable = 0, ram_address = 0.
  - ram_data released (Z).
- Reset mid-access aborts immediately. Enable drops asynchronously, the bus releases, and no rsp_valid is issued.
- States: IDLE -> SETUP -> ACCESS -> TURN -> IDLE.
- IDLE:
  - req_ready = 1.
  - A handshake (req_valid & req_ready) latches we, addr and wdata, then goes to SETUP.
  - Request inputs are ignored outside the handshake cycle.
- SETUP (1 cycle):
  - ram_address = latched addr; ram_enable = 0.
  - For a write, ram_data drives the latched wdata. For a read, ram_data = Z.
- ACCESS (WAIT_CYCLES cycles, counted by a down-counter):
  - ram_enable = 1, ram_write_enable = latched we.
  - Address and data are held stable.
  - Reads sample ram_data into rsp_rdata on the clock edge ending the last ACCESS cycle.
- TURN (1 cycle):
  - ram_enable = 0, ram_write_enable = 0.
  - Write data keeps being driven for hold; it releases to Z on exit.
  - rsp_valid = 1 for this cycle only.
- req_ready = 0 in SETUP, ACCESS and TURN; no pipelining.
- Latency, handshake edge to rsp_valid: WAIT_CYCLES + 2 cycles. Throughput is 1 access per WAIT_CYCLES + 3 cycles.
- ram_write_enable never changes while ram_enable = 1.
- ram_data is never driven while ram_enable & ~ram_write_enable, so there is no contention with RAM read drive.
- ram_address retains its last value in IDLE.
- Write responses leave rsp_rdata unchanged.
- Address arithmetic: none in the base block; addresses pass through unmodified.

Optional Feature:
- Macro: RAM_CTRL_READBACK_EN.
- When defined, every write is followed by an internal read of the same address (states VSETUP, VACCESS, inserted before TURN).
  - The read-back byte is compared against the latched wdata.
  - rsp_err = 1 with rsp_valid on mismatch; otherwise 0.
  - rsp_rdata is not updated by the read-back.
  - Write latency becomes 2*WAIT_CYCLES + 3. Read latency is unchanged.
- When undefined, rsp_err is tied 0 and write latency is WAIT_CYCLES + 2.

Decomposition:
- Package ram_ctrl_pkg holds:
  - ADDR_W and DATA_W defaults.
  - The state encoding (IDLE, SETUP, ACCESS, TURN, VSETUP, VACCESS) as 3-bit localparams.
  - Wait counter width (4).
- One natural sub-module: ram_ctrl_wait_cnt, a loadable down-counter with a zero flag that times the ACCESS and VACCESS phases.
- Tri-state drive and the FSM stay in ram_ctrl.

Test Plan:
- Reset: assert rst_n = 0 mid-ACCESS of a write -> same-cycle ram_enable = 0, ram_data = Z, req_ready = 1 after release, no rsp_valid.
- Write then read: write addr 0x123, data 0x5A, then read 0x123 -> rsp_rdata = 0x5A; rsp_valid exactly WAIT_CYCLES + 2 cycles after each handshake.
- Bus discipline: checker on every cycle asserts no driven ram_data while the RAM reads, and write_enable stable while enable = 1; run 200 random accesses with WAIT_CYCLES = 1 and 3.
- Back-to-back: req_valid held high with 3 queued requests -> req_ready low during each access; requests accepted every WAIT_CYCLES + 3 cycles; responses in order.
- Address boundaries: write 0xFF to 0x000 and 0x00 to 0xFFF, read both -> 0xFF and 0x00; other addresses unchanged.
- Readback (RAM_CTRL_READBACK_EN defined): model write-protected cell 0x010 holding 0x11, write 0x22 -> rsp_err = 1; normal cell -> rsp_err = 0, latency 2*WAIT_CYCLES + 3.
